cmd_initiator: RTL and testbench

//  Host-side initiator of the emulator serial command protocol. It frames one

---
 rtl/cmd_initiator.sv | 161 ++++++++++++++++
 tb/tb_cmd_initiator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_initiator.sv
// cmd_initiator: host-side framer for the emulator serial command protocol.
// Sends cmd plus LE args on TX, assembles a LE reply from RX, forwards stray RX.
module cmd_initiator #(
    parameter int MAX_BYTES      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [7:0]             req_cmd,
    input  logic [8*MAX_BYTES-1:0] req_arg,
    input  logic [2:0]             req_arg_len,
    input  logic [2:0]             req_rsp_len,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [7:0]             tx_data,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   rsp_valid,
    output logic [8*MAX_BYTES-1:0] rsp_data,
    output logic                   rsp_timeout,
    output logic                   evt_valid,
    output logic [7:0]             evt_data
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [2:0] MAXB = 3'(MAX_BYTES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_ARG,
        WAIT_RSP,
        DONE
    } state_t;

    state_t state_q, state_d, after_tx;

    logic [7:0]             cmd_q;
    logic [8*MAX_BYTES-1:0] arg_q;
    logic [2:0]             arg_len_q;
    logic [2:0]             rsp_len_q;
    logic [2:0]             idx_q;
    logic [TW-1:0]          tmo_q;

    logic accept;
    logic arg_fire;
    logic rsp_fire;
    logic last_arg;
    logic last_rsp;
    logic tmo_hit;
    logic stray;

    function automatic logic [2:0] clamp(input logic [2:0] len);
        return (len > MAXB) ? MAXB : len;
    endfunction

    assign req_ready = (state_q == IDLE);
    assign tx_valid  = (state_q == SEND_CMD) || (state_q == SEND_ARG);
    assign rsp_valid = (state_q == DONE);

    assign accept   = req_valid && req_ready;
    assign arg_fire = (state_q == SEND_ARG) && tx_ready;
    assign rsp_fire = (state_q == WAIT_RSP) && rx_valid;
    assign last_arg = (idx_q + 3'd1) == arg_len_q;
    assign last_rsp = (idx_q + 3'd1) == rsp_len_q;
    assign stray    = rx_valid && (state_q != WAIT_RSP);

    // An rx byte in the final idle cycle beats the timeout.
    assign tmo_hit  = !rx_valid && (tmo_q == TMO_LAST);

    assign after_tx = (rsp_len_q != 3'd0) ? WAIT_RSP : DONE;

    always_comb begin
        tx_data = 8'h00;
        unique case (1'b1)
            state_q == SEND_CMD: tx_data = cmd_q;
            state_q == SEND_ARG: tx_data = arg_q[7:0];
            default:             tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) state_d = SEND_CMD;
            end
            SEND_CMD: begin
                if (tx_ready) begin
                    state_d = (arg_len_q != 3'd0) ? SEND_ARG : after_tx;
                end
            end
            SEND_ARG: begin
                if (tx_ready && last_arg) state_d = after_tx;
            end
            WAIT_RSP: begin
                if ((rx_valid && last_rsp) || tmo_hit) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q       <= 8'h00;
            arg_q       <= '0;
            arg_len_q   <= 3'd0;
            rsp_len_q   <= 3'd0;
            idx_q       <= 3'd0;
            tmo_q       <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            evt_valid   <= 1'b0;
            evt_data    <= 8'h00;
        end else begin
            if (accept) begin
                cmd_q       <= req_cmd;
                arg_q       <= req_arg;
                arg_len_q   <= clamp(req_arg_len);
                rsp_len_q   <= clamp(req_rsp_len);
                rsp_data    <= '0;
                rsp_timeout <= 1'b0;
            end

            if (arg_fire) arg_q <= arg_q >> 8;

            if (state_q != state_d) begin
                idx_q <= 3'd0;
            end else if ((arg_fire || rsp_fire) && idx_q < MAXB) begin
                idx_q <= idx_q + 3'd1;
            end

            if (state_q != WAIT_RSP || rx_valid) begin
                tmo_q <= '0;
            end else if (tmo_q != TMO_LAST) begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (rsp_fire) begin
                for (int k = 0; k < MAX_BYTES; k++) begin
                    if (idx_q == 3'(k)) rsp_data[8*k +: 8] <= rx_data;
                end
            end

            if (state_q == WAIT_RSP && tmo_hit) rsp_timeout <= 1'b1;

            evt_valid <= stray;
            if (stray) evt_data <= rx_data;
        end
    end

endmodule

// File: tb/tb_cmd_initiator.sv
// tb_cmd_initiator: randomized transaction-level check of cmd_initiator.
// Expected bytes, replies, timeouts and events come from a queue-based model.
module tb_cmd_initiator;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = 8'h00;
    logic [31:0] req_arg = 32'h0;
    logic [2:0]  req_arg_len = 3'd0;
    logic [2:0]  req_rsp_len = 3'd0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        evt_valid;
    logic [7:0]  evt_data;

    always #5 clk = ~clk;

    cmd_initiator #(
        .MAX_BYTES(4),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cmd(req_cmd),
        .req_arg(req_arg),
        .req_arg_len(req_arg_len),
        .req_rsp_len(req_rsp_len),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout),
        .evt_valid(evt_valid),
        .evt_data(evt_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] got_tx[$];
    logic [7:0] exp_evt[$];
    logic [7:0] got_evt[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic       stall_q = 1'b0;
    logic [7:0] stall_data = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                check("tx_hold_valid", 32'(tx_valid), 32'd1);
                check("tx_hold_data", 32'(tx_data), 32'(stall_data));
            end
            if (tx_valid && tx_ready) got_tx.push_back(tx_data);
            if (evt_valid) got_evt.push_back(evt_data);
            stall_q    <= tx_valid && !tx_ready;
            stall_data <= tx_data;
        end
    end

    task automatic send_evt(input logic [7:0] b);
        check("evt_no_rsp", 32'(rsp_valid), 32'd0);
        rx_valid = 1'b1;
        rx_data  = b;
        exp_evt.push_back(b);
        tick();
        rx_valid = 1'b0;
    endtask

    // rmode: 0 always ready, 1 toggling, 2 random. gap < 0 means random.
    task automatic run_txn(input logic [7:0] cmd, input logic [31:0] arg,
                           input logic [2:0] alen, input logic [2:0] rlen,
                           input int ndeliv, input int gap,
                           input int rmode, input bit inj);
        int na;
        int nr;
        int hs;
        int t;
        int g;
        logic [31:0] exp_data;
        logic        exp_to;
        logic [7:0]  b;

        na = (alen > 3'd4) ? 4 : int'(alen);
        nr = (rlen > 3'd4) ? 4 : int'(rlen);
        exp_tx.delete();
        got_tx.delete();
        exp_tx.push_back(cmd);
        for (int i = 0; i < na; i++) exp_tx.push_back(arg[8*i +: 8]);

        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_cmd     = cmd;
        req_arg     = arg;
        req_arg_len = alen;
        req_rsp_len = rlen;
        tick();
        req_valid   = 1'b0;
        req_cmd     = 8'($urandom);
        req_arg     = $urandom;
        req_arg_len = 3'($urandom);
        req_rsp_len = 3'($urandom);

        check("tx_first_valid", 32'(tx_valid), 32'd1);
        check("tx_first_data", 32'(tx_data), 32'(cmd));
        check("req_ready_busy", 32'(req_ready), 32'd0);

        hs = 0;
        t  = 0;
        while (hs < na + 1 && t < 200) begin
            case (rmode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (t % 2 == 0);
                default: tx_ready = 1'($urandom);
            endcase
            if (inj && tx_valid && $urandom_range(0, 3) == 0) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
                exp_evt.push_back(rx_data);
            end
            if (tx_valid && tx_ready) hs++;
            tick();
            rx_valid = 1'b0;
            t++;
        end
        tx_ready = 1'b0;
        check("tx_hs_bound", 32'(hs), 32'(na + 1));

        check("tx_count", 32'(got_tx.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
            check("tx_byte", 32'(got_tx[i]), 32'(exp_tx[i]));
        end

        exp_data = 32'h0;
        exp_to   = 1'b0;
        if (nr == 0) begin
            check("rsp_after_tx", 32'(rsp_valid), 32'd1);
        end else begin
            for (int k = 0; k < ndeliv && k < nr; k++) begin
                g = (gap >= 0) ? gap : $urandom_range(0, T - 1);
                repeat (g) begin
                    check("rsp_early", 32'(rsp_valid), 32'd0);
                    tick();
                end
                check("rsp_early", 32'(rsp_valid), 32'd0);
                b = 8'($urandom);
                rx_valid = 1'b1;
                rx_data  = b;
                exp_data[8*k +: 8] = b;
                tick();
                rx_valid = 1'b0;
            end
            if (ndeliv >= nr) begin
                check("rsp_after_rx", 32'(rsp_valid), 32'd1);
            end else begin
                exp_to = 1'b1;
                t = 0;
                while (!rsp_valid && t < 4 * T) begin
                    tick();
                    t++;
                end
                check("timeout_latency", 32'(t), 32'(T));
            end
        end

        check("rsp_data", rsp_data, exp_data);
        check("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
        check("done_not_ready", 32'(req_ready), 32'd0);

        if (inj && $urandom_range(0, 1) == 1) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            exp_evt.push_back(rx_data);
        end
        tick();
        rx_valid = 1'b0;
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("rsp_hold", rsp_data, exp_data);
        check("to_hold", 32'(rsp_timeout), 32'(exp_to));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [2:0] al;
        logic [2:0] rl;
        int nd;
        int nr;

        repeat (2) tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_to", 32'(rsp_timeout), 32'd0);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_data", 32'(evt_data), 32'd0);
        rst = 1'b1;
        tick();

        run_txn("I", 32'h0, 3'd0, 3'd0, 0, 0, 0, 1'b0);
        run_txn("A", 32'h0000_1234, 3'd2, 3'd0, 0, 0, 1, 1'b0);
        run_txn("a", 32'h0, 3'd0, 3'd2, 2, 5, 0, 1'b0);
        run_txn("b", 32'h0, 3'd0, 3'd1, 0, 0, 0, 1'b0);
        run_txn("b", 32'h0, 3'd0, 3'd1, 1, T - 1, 0, 1'b0);

        send_evt("#");
        send_evt("B");
        send_evt("R");
        send_evt("K");
        tick();
        check("evt_no_rsp_after", 32'(rsp_valid), 32'd0);

        run_txn("M", 32'hDEAD_BEEF, 3'd7, 3'd6, 4, -1, 2, 1'b1);

        req_valid   = 1'b1;
        req_cmd     = "W";
        req_arg     = 32'h8765_4321;
        req_arg_len = 3'd4;
        req_rsp_len = 3'd2;
        tick();
        req_valid = 1'b0;
        tx_ready  = 1'b1;
        tick();
        tx_ready  = 1'b0;
        tick();
        tick();
        check("stall_arg_valid", 32'(tx_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_tx_valid", 32'(tx_valid), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_tx_data", 32'(tx_data), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        run_txn("R", 32'h0000_00A5, 3'd1, 3'd4, 4, -1, 2, 1'b0);

        for (int n = 0; n < 40; n++) begin
            al = 3'($urandom_range(0, 7));
            rl = 3'($urandom_range(0, 7));
            nr = (rl > 3'd4) ? 4 : int'(rl);
            nd = nr;
            if (nr > 0 && $urandom_range(0, 4) == 0) nd = $urandom_range(0, nr - 1);
            run_txn(8'($urandom), $urandom, al, rl, nd, -1, 2, 1'b1);
            repeat ($urandom_range(0, 2)) send_evt(8'($urandom));
        end

        repeat (3) tick();
        check("evt_count", 32'(got_evt.size()), 32'(exp_evt.size()));
        for (int i = 0; i < exp_evt.size() && i < got_evt.size(); i++) begin
            check("evt_byte", 32'(got_evt[i]), 32'(exp_evt[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
